// File: rtl/blob_bbox_tracker.sv
// Thresholds one grayscale frame and reports the bounding box and pixel count
// of above-threshold pixels, raising a blob-end level once the frame is complete.
module blob_bbox_tracker #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned XW        = 12,
    parameter int unsigned YW        = 12,
    parameter int unsigned CW        = 20,
    parameter int unsigned MIN_COUNT = 64
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_pix_valid,
    input  logic [XW-1:0] i_pix_x,
    input  logic [YW-1:0] i_pix_y,
    input  logic [7:0]    i_gray,
    input  logic [7:0]    i_threshold,
    output logic          o_blob_end,
    output logic          o_found,
    output logic [XW-1:0] o_x_min,
    output logic [XW-1:0] o_x_max,
    output logic [YW-1:0] o_y_min,
    output logic [YW-1:0] o_y_max,
    output logic [CW-1:0] o_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_ACCUM,
        S_LOAD,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [7:0]    thr_r;
    logic [XW-1:0] acc_xmin, acc_xmax, base_xmin, base_xmax, nxt_xmin, nxt_xmax;
    logic [YW-1:0] acc_ymin, acc_ymax, base_ymin, base_ymax, nxt_ymin, nxt_ymax;
    logic [CW-1:0] acc_cnt, base_cnt, nxt_cnt;

    logic in_range, is_sof, is_eof, hit;
    logic proc, init, load, thr_load, blob_end_nxt;

    assign in_range = i_pix_valid && (i_pix_x < XW'(H_ACTIVE)) && (i_pix_y < YW'(V_ACTIVE));
    assign is_sof   = in_range && (i_pix_x == '0) && (i_pix_y == '0);
    assign is_eof   = in_range && (i_pix_x == XW'(H_ACTIVE - 1)) && (i_pix_y == YW'(V_ACTIVE - 1));
    assign hit      = in_range && (i_gray > thr_r);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        proc         = 1'b0;
        init         = 1'b0;
        load         = 1'b0;
        thr_load     = 1'b0;
        blob_end_nxt = o_blob_end;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    thr_load  = 1'b1;
                    state_nxt = S_WAIT_SOF;
                end
            end
            S_WAIT_SOF: begin
                if (!i_start) begin
                    state_nxt = S_IDLE;
                end else if (is_sof) begin
                    proc      = 1'b1;
                    init      = 1'b1;
                    state_nxt = is_eof ? S_LOAD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (!i_start) begin
                    state_nxt = S_IDLE;
                end else begin
                    proc = 1'b1;
                    if (is_eof) state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                load         = 1'b1;
                blob_end_nxt = 1'b1;
                state_nxt    = S_DONE;
            end
            S_DONE: begin
                if (!i_start) begin
                    blob_end_nxt = 1'b0;
                    state_nxt    = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // First pixel of a frame merges into the sentinel values rather than stale state.
    always_comb begin
        base_xmin = init ? '1 : acc_xmin;
        base_xmax = init ? '0 : acc_xmax;
        base_ymin = init ? '1 : acc_ymin;
        base_ymax = init ? '0 : acc_ymax;
        base_cnt  = init ? '0 : acc_cnt;
        nxt_xmin  = base_xmin;
        nxt_xmax  = base_xmax;
        nxt_ymin  = base_ymin;
        nxt_ymax  = base_ymax;
        nxt_cnt   = base_cnt;
        if (hit) begin
            if (i_pix_x < base_xmin) nxt_xmin = i_pix_x;
            if (i_pix_x > base_xmax) nxt_xmax = i_pix_x;
            if (i_pix_y < base_ymin) nxt_ymin = i_pix_y;
            if (i_pix_y > base_ymax) nxt_ymax = i_pix_y;
            if (base_cnt != '1)      nxt_cnt  = base_cnt + CW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            thr_r    <= '0;
            acc_xmin <= '0;
            acc_xmax <= '0;
            acc_ymin <= '0;
            acc_ymax <= '0;
            acc_cnt  <= '0;
        end else begin
            if (thr_load) thr_r <= i_threshold;
            if (proc) begin
                acc_xmin <= nxt_xmin;
                acc_xmax <= nxt_xmax;
                acc_ymin <= nxt_ymin;
                acc_ymax <= nxt_ymax;
                acc_cnt  <= nxt_cnt;
            end
        end
    end

    // Result registers move only on the end-of-frame load; an empty frame exports zeros.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_blob_end <= 1'b0;
            o_found    <= 1'b0;
            o_x_min    <= '0;
            o_x_max    <= '0;
            o_y_min    <= '0;
            o_y_max    <= '0;
            o_count    <= '0;
        end else begin
            o_blob_end <= blob_end_nxt;
            if (load) begin
                o_count <= acc_cnt;
                o_found <= (acc_cnt >= CW'(MIN_COUNT));
                if (acc_cnt == '0) begin
                    o_x_min <= '0;
                    o_x_max <= '0;
                    o_y_min <= '0;
                    o_y_max <= '0;
                end else begin
                    o_x_min <= acc_xmin;
                    o_x_max <= acc_xmax;
                    o_y_min <= acc_ymin;
                    o_y_max <= acc_ymax;
                end
            end
        end
    end

endmodule

// File: tb/tb_blob_bbox_tracker.sv
// Directed bench for blob_bbox_tracker on a reduced 64x48 frame; test-plan
// geometry is scaled down (square at x=20.., y=10..; corner hit at (63,47)).
module tb_blob_bbox_tracker;

    localparam int H    = 64;
    localparam int V    = 48;
    localparam int XW   = 12;
    localparam int YW   = 12;
    localparam int CW   = 20;
    localparam int MINC = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          valid;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic [7:0]    gray;
    logic [7:0]    thr;
    logic          blob_end;
    logic          found;
    logic [XW-1:0] x_min, x_max;
    logic [YW-1:0] y_min, y_max;
    logic [CW-1:0] count;

    int n_asserts = 0;
    int n_fails   = 0;

    blob_bbox_tracker #(
        .H_ACTIVE(H), .V_ACTIVE(V), .XW(XW), .YW(YW), .CW(CW), .MIN_COUNT(MINC)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_pix_valid(valid),
        .i_pix_x(px), .i_pix_y(py), .i_gray(gray), .i_threshold(thr),
        .o_blob_end(blob_end), .o_found(found), .o_x_min(x_min), .o_x_max(x_max),
        .o_y_min(y_min), .o_y_max(y_max), .o_count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_res(input string tag, input int xmn, input int xmx, input int ymn,
                             input int ymx, input int cnt, input int fnd);
        check({tag, ".x_min"}, 32'(x_min), 32'(xmn));
        check({tag, ".x_max"}, 32'(x_max), 32'(xmx));
        check({tag, ".y_min"}, 32'(y_min), 32'(ymn));
        check({tag, ".y_max"}, 32'(y_max), 32'(ymx));
        check({tag, ".count"}, 32'(count), 32'(cnt));
        check({tag, ".found"}, 32'(found), 32'(fnd));
    endtask

    // kind: 0 = 10x10 square, 1 = 5x5 square, 2 = dark, 3 = only the corner pixel set to g
    function automatic logic [7:0] gray_at(input int kind, input int x, input int y, input logic [7:0] g);
        case (kind)
            0:       return (x >= 20 && x <= 29 && y >= 10 && y <= 19) ? 8'd200 : 8'd50;
            1:       return (x >= 20 && x <= 24 && y >= 10 && y <= 14) ? 8'd200 : 8'd50;
            3:       return (x == H - 1 && y == V - 1) ? g : 8'd50;
            default: return 8'd50;
        endcase
    endfunction

    // Streams one frame at threshold 100, then lowers the threshold mid-frame to prove it is latched.
    task automatic run_frame(input string tag, input int kind, input logic [7:0] g,
                             input int abort_y, input bit stray);
        start = 1'b1;
        thr   = 8'd100;
        valid = 1'b0;
        step();
        if (stray) begin
            valid = 1'b1; px = XW'(5); py = YW'(5); gray = 8'd255;
            step();
        end
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < W_OF(); x++) begin
                if (y == abort_y && x == 0) start = 1'b0;
                if (y == 1 && x == 0) thr = 8'd0;
                if (stray && y == 5 && x == 0) begin
                    valid = 1'b1; px = XW'(H + 6); py = YW'(5); gray = 8'd255;
                    step();
                    px = XW'(3); py = YW'(V + 2);
                    step();
                end
                valid = 1'b1;
                px    = XW'(x);
                py    = YW'(y);
                gray  = gray_at(kind, x, y, g);
                step();
            end
        end
        valid = 1'b0;
        if (abort_y < 0) begin
            check({tag, ".blob_end_n"}, 32'(blob_end), 32'd0);
            step();
            check({tag, ".blob_end_n1"}, 32'(blob_end), 32'd1);
        end else begin
            step();
            check({tag, ".blob_end_abort"}, 32'(blob_end), 32'd0);
        end
    endtask

    function automatic int W_OF();
        return H;
    endfunction

    task automatic end_frame(input string tag);
        start = 1'b0;
        valid = 1'b0;
        step();
        check({tag, ".blob_end_clr"}, 32'(blob_end), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0; px = '0; py = '0; gray = '0; thr = '0;
        step();
        check_res("reset", 0, 0, 0, 0, 0, 0);
        check("reset.blob_end", 32'(blob_end), 32'd0);
        rst = 1'b0;
        step();

        run_frame("sq10", 0, 8'd0, -1, 1'b0);
        check_res("sq10", 20, 29, 10, 19, 100, 1);
        // start still high in S_DONE: a fresh frame must not begin
        valid = 1'b1; px = '0; py = '0; gray = 8'd255;
        step();
        px = XW'(H - 1); py = YW'(V - 1);
        step(); step();
        valid = 1'b0;
        check("hold.blob_end", 32'(blob_end), 32'd1);
        check("hold.count", 32'(count), 32'd100);
        end_frame("sq10");
        check("idle.count", 32'(count), 32'd100);

        run_frame("sq5", 1, 8'd0, -1, 1'b0);
        check_res("sq5", 20, 24, 10, 14, 25, 0);
        end_frame("sq5");

        run_frame("dark", 2, 8'd0, -1, 1'b1);
        check_res("dark", 0, 0, 0, 0, 0, 0);
        end_frame("dark");

        run_frame("corner101", 3, 8'd101, -1, 1'b0);
        check_res("corner101", H - 1, H - 1, V - 1, V - 1, 1, 0);
        end_frame("corner101");

        run_frame("corner100", 3, 8'd100, -1, 1'b0);
        check_res("corner100", 0, 0, 0, 0, 0, 0);
        end_frame("corner100");

        run_frame("sq10b", 0, 8'd0, -1, 1'b0);
        check_res("sq10b", 20, 29, 10, 19, 100, 1);
        end_frame("sq10b");

        run_frame("abort", 1, 8'd0, V / 2, 1'b0);
        check_res("abort", 20, 29, 10, 19, 100, 1);
        end_frame("abort");

        run_frame("sq5b", 1, 8'd0, -1, 1'b0);
        check_res("sq5b", 20, 24, 10, 14, 25, 0);
        // asynchronous reset while in S_DONE, observed before the next clock edge
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst.blob_end", 32'(blob_end), 32'd0);
        check_res("arst", 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        step();
        check("arst.idle_blob_end", 32'(blob_end), 32'd0);
        start = 1'b0;
        step(); step();
        check("post_arst.blob_end", 32'(blob_end), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
